// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level shared definitions: response data selection and default error pattern.
package core_v_mini_mcu_pkg;

  // Which source drives rdata in the cycle rvalid is high.
  typedef enum logic [1:0] {
    RSP_READ = 2'd0,
    RSP_ZERO = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_sel_e;

  localparam logic [31:0] OBI_ERR_RDATA = 32'hBADC_AB1E;

  // True when some but not all byte lanes are enabled.
  function automatic logic be_is_partial(input logic [3:0] be);
    return (be != 4'h0) && (be != 4'hF);
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by initiators, crossbar and responders.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take new data, the rest keep old data.
module obi_byte_merge (
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign merged[8*k +: 8] = be[k] ? wdata[8*k +: 8] : rdata[8*k +: 8];
  end

endmodule

// File: rtl/obi_rmw_sram_responder.sv
// OBI responder for a word-write-only SRAM; partial-byte writes become read-modify-write.
// Valid/ready: a transaction is accepted in the cycle req && gnt; its single rvalid follows one cycle later, with no backpressure and at most one outstanding.
module obi_rmw_sram_responder
  import obi_pkg::*;
  import core_v_mini_mcu_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8192,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ERR_RDATA = OBI_ERR_RDATA
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  obi_req_t                     req_i,
  output obi_resp_t                    resp_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(NUM_WORDS)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         rmw_busy_o
);

  localparam int unsigned AW   = $clog2(NUM_WORDS);
  localparam logic [32:0] SPAN = 33'(NUM_WORDS) << 2;

  typedef enum logic {
    IDLE     = 1'b0,
    RMW_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  rsp_sel_e    sel_q, sel_d;
  logic        rvalid_q;
  logic        gnt;
  logic        mem_req;
  logic        mem_we;
  logic        rmw_busy;
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [31:0] merged;
  logic [31:0] rdata_mux;

  // Wrap-around subtraction also rejects addresses below BASE_ADDR.
  assign offset   = req_i.addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign idx      = req_i.addr[2 +: AW];

  obi_byte_merge u_merge (
    .be     (req_i.be),
    .wdata  (req_i.wdata),
    .rdata  (mem_rdata_i),
    .merged (merged)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = RSP_ZERO;
    gnt         = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_wdata_o = req_i.wdata;
    rmw_busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i.req) begin
          if (!in_range) begin
            gnt   = 1'b1;
            sel_d = req_i.we ? RSP_ZERO : RSP_ERR;
          end else if (!req_i.we) begin
            gnt     = 1'b1;
            mem_req = 1'b1;
            sel_d   = RSP_READ;
          end else if (req_i.be == 4'hF) begin
            gnt     = 1'b1;
            mem_req = 1'b1;
            mem_we  = 1'b1;
          end else if (!be_is_partial(req_i.be)) begin
            gnt = 1'b1;
          end else begin
            // Fetch the old word now; grant once the merged word is written.
            mem_req = 1'b1;
            state_d = RMW_WAIT;
          end
        end
      end
      RMW_WAIT: begin
        gnt         = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_wdata_o = merged;
        rmw_busy    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      gnt      = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      rmw_busy = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      sel_q    <= RSP_ZERO;
    end else begin
      state_q  <= state_d;
      rvalid_q <= gnt;
      if (gnt) sel_q <= sel_d;
    end
  end

  always_comb begin
    rdata_mux = 32'h0;
    unique case (sel_q)
      RSP_READ: rdata_mux = mem_rdata_i;
      RSP_ERR:  rdata_mux = ERR_RDATA;
      default:  rdata_mux = 32'h0;
    endcase
  end

  assign resp_o.gnt    = gnt;
  assign resp_o.rvalid = rvalid_q;
  assign resp_o.rdata  = rvalid_q ? rdata_mux : 32'h0;
  assign mem_req_o     = mem_req;
  assign mem_we_o      = mem_we;
  assign mem_addr_o    = idx;
  assign rmw_busy_o    = rmw_busy;

  // The second RMW cycle depends on the initiator still presenting its request.
  a_rmw_req_held: assert property (
    @(posedge clk_i) disable iff (rst_i) (state_q == RMW_WAIT) |-> req_i.req
  );

endmodule

// File: tb/tb_obi_rmw_sram_responder.sv
// Directed bench for obi_rmw_sram_responder with a behavioural single-port SRAM.
module tb_obi_rmw_sram_responder;
  import obi_pkg::*;

  localparam int unsigned NUM_WORDS = 64;
  localparam logic [31:0] BASE      = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  obi_req_t    req;
  obi_resp_t   resp;
  logic        mem_req, mem_we, rmw_busy;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [NUM_WORDS];
  logic        bd_en = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          we_count = 0;
  int          req_count = 0;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  obi_rmw_sram_responder #(
    .NUM_WORDS (NUM_WORDS),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .resp_o      (resp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .rmw_busy_o  (rmw_busy)
  );

  // SRAM model: read data appears the cycle after a read enable.
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (mem_req) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
    if (mem_req && mem_we) we_count <= we_count + 1;
    if (mem_req) req_count <= req_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req.req = 1'b1; req.we = we; req.be = be; req.addr = addr; req.wdata = wdata;
  endtask

  task automatic drive_idle();
    req.req = 1'b0; req.we = 1'b0; req.be = 4'h0; req.addr = '0; req.wdata = '0;
  endtask

  task automatic backdoor_write(input logic [5:0] a, input logic [31:0] d);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_en = 1'b0;
  endtask

  task automatic test_reset();
    drive_req(1'b0, 4'hF, BASE, 32'h0);
    #2;
    checks++; if (resp.gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt: got %b want 0", resp.gnt); end
    checks++; if (resp.rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", resp.rvalid); end
    checks++; if (resp.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", resp.rdata); end
    checks++; if ({mem_req, mem_we, rmw_busy} !== 3'b000) begin fails++; $display("FAIL reset_mem: got %b want 000", {mem_req, mem_we, rmw_busy}); end
    step();
    drive_idle();
    rst = 1'b0;
    step();
    checks++; if (resp.rvalid !== 1'b0) begin fails++; $display("FAIL post_reset_rvalid: got %b want 0", resp.rvalid); end
    for (int i = 0; i < 8; i++) backdoor_write(6'(i), 32'hC0DE_0000 + 32'(i));
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checks++; if (resp.rvalid !== 1'b1) begin fails++; $display("FAIL b2b_rvalid[%0d]: got %b want 1", i-1, resp.rvalid); end
        checks++; if (resp.rdata !== 32'hC0DE_0000 + 32'(i-1)) begin fails++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i-1, resp.rdata, 32'hC0DE_0000 + 32'(i-1)); end
      end
      if (i < 8) begin
        drive_req(1'b0, 4'hF, BASE + 32'(4*i), 32'h0);
        #1;
        checks++; if (resp.gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, resp.gnt); end
      end else drive_idle();
      step();
    end
    checks++; if (resp.rvalid !== 1'b0) begin fails++; $display("FAIL b2b_tail_rvalid: got %b want 0", resp.rvalid); end
  endtask

  task automatic test_full_write_read();
    int w0;
    w0 = we_count;
    drive_req(1'b1, 4'hF, BASE + 32'h10, 32'h1122_3344);
    #1;
    checks++; if (resp.gnt !== 1'b1) begin fails++; $display("FAIL fw_gnt: got %b want 1", resp.gnt); end
    checks++; if ({mem_req, mem_we} !== 2'b11) begin fails++; $display("FAIL fw_mem_ctl: got %b want 11", {mem_req, mem_we}); end
    checks++; if (mem_addr !== 6'd4) begin fails++; $display("FAIL fw_mem_addr: got %0d want 4", mem_addr); end
    checks++; if (mem_wdata !== 32'h1122_3344) begin fails++; $display("FAIL fw_mem_wdata: got %h want 11223344", mem_wdata); end
    step();
    checks++; if ({resp.rvalid, resp.rdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL fw_resp: got %b/%h want 1/0", resp.rvalid, resp.rdata); end
    drive_req(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    #1;
    checks++; if ({resp.gnt, mem_req, mem_we} !== 3'b110) begin fails++; $display("FAIL rd_ctl: got %b want 110", {resp.gnt, mem_req, mem_we}); end
    step();
    checks++; if ({resp.rvalid, resp.rdata} !== {1'b1, 32'h1122_3344}) begin fails++; $display("FAIL rd_after_wr: got %b/%h want 1/11223344", resp.rvalid, resp.rdata); end
    drive_idle();
    step();
    checks++; if (we_count - w0 !== 1) begin fails++; $display("FAIL fw_we_pulses: got %0d want 1", we_count - w0); end
  endtask

  task automatic test_partial_rmw();
    backdoor_write(6'd5, 32'hAABB_CCDD);
    drive_req(1'b1, 4'b0101, BASE + 32'h14, 32'h1122_3344);
    #1;
    checks++; if ({resp.gnt, mem_req, mem_we, rmw_busy} !== 4'b0100) begin fails++; $display("FAIL rmw_c1: got %b want 0100", {resp.gnt, mem_req, mem_we, rmw_busy}); end
    checks++; if (mem_addr !== 6'd5) begin fails++; $display("FAIL rmw_c1_addr: got %0d want 5", mem_addr); end
    step();
    checks++; if (resp.rvalid !== 1'b0) begin fails++; $display("FAIL rmw_c2_rvalid: got %b want 0", resp.rvalid); end
    checks++; if ({resp.gnt, mem_req, mem_we, rmw_busy} !== 4'b1111) begin fails++; $display("FAIL rmw_c2: got %b want 1111", {resp.gnt, mem_req, mem_we, rmw_busy}); end
    checks++; if (mem_wdata !== 32'hAA22_CC44) begin fails++; $display("FAIL rmw_merge: got %h want aa22cc44", mem_wdata); end
    step();
    checks++; if ({resp.rvalid, resp.rdata, rmw_busy} !== {1'b1, 32'h0, 1'b0}) begin fails++; $display("FAIL rmw_c3: got %b/%h/%b want 1/0/0", resp.rvalid, resp.rdata, rmw_busy); end
    drive_req(1'b0, 4'hF, BASE + 32'h14, 32'h0);
    #1;
    checks++; if (resp.gnt !== 1'b1) begin fails++; $display("FAIL rmw_rd_gnt: got %b want 1", resp.gnt); end
    step();
    checks++; if (resp.rdata !== 32'hAA22_CC44) begin fails++; $display("FAIL rmw_readback: got %h want aa22cc44", resp.rdata); end
    drive_idle();
    step();
  endtask

  task automatic test_out_of_range();
    int r0;
    r0 = req_count;
    drive_req(1'b0, 4'hF, BASE + NUM_WORDS*4, 32'h0);
    #1;
    checks++; if ({resp.gnt, mem_req} !== 2'b10) begin fails++; $display("FAIL oor_rd_ctl: got %b want 10", {resp.gnt, mem_req}); end
    step();
    checks++; if ({resp.rvalid, resp.rdata} !== {1'b1, 32'hBADC_AB1E}) begin fails++; $display("FAIL oor_rd_resp: got %b/%h want 1/badcab1e", resp.rvalid, resp.rdata); end
    drive_req(1'b1, 4'hF, BASE + NUM_WORDS*4, 32'hDEAD_BEEF);
    #1;
    checks++; if ({resp.gnt, mem_req} !== 2'b10) begin fails++; $display("FAIL oor_wr_ctl: got %b want 10", {resp.gnt, mem_req}); end
    step();
    checks++; if ({resp.rvalid, resp.rdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL oor_wr_resp: got %b/%h want 1/0", resp.rvalid, resp.rdata); end
    drive_req(1'b0, 4'hF, BASE - 32'h4, 32'h0);
    step();
    checks++; if (resp.rdata !== 32'hBADC_AB1E) begin fails++; $display("FAIL oor_below_base: got %h want badcab1e", resp.rdata); end
    checks++; if (req_count !== r0) begin fails++; $display("FAIL oor_mem_req: got %0d want %0d", req_count, r0); end
    drive_req(1'b0, 4'hF, BASE + NUM_WORDS*4 - 4, 32'h0);
    #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 6'd63}) begin fails++; $display("FAIL last_word: got %b/%0d want 1/63", mem_req, mem_addr); end
    step();
    drive_idle();
    step();
  endtask

  task automatic test_be_zero();
    int r0;
    r0 = req_count;
    drive_req(1'b1, 4'h0, BASE + 32'h18, 32'hFFFF_FFFF);
    #1;
    checks++; if ({resp.gnt, mem_req} !== 2'b10) begin fails++; $display("FAIL be0_ctl: got %b want 10", {resp.gnt, mem_req}); end
    step();
    checks++; if ({resp.rvalid, resp.rdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL be0_resp: got %b/%h want 1/0", resp.rvalid, resp.rdata); end
    drive_idle();
    step();
    checks++; if (mem[6] !== 32'hC0DE_0006) begin fails++; $display("FAIL be0_mem: got %h want c0de0006", mem[6]); end
    checks++; if (req_count !== r0) begin fails++; $display("FAIL be0_mem_req: got %0d want %0d", req_count, r0); end
  endtask

  task automatic test_reset_mid_rmw();
    int w0;
    w0 = we_count;
    drive_req(1'b1, 4'b0011, BASE + 32'h1C, 32'h0);
    step();
    checks++; if (rmw_busy !== 1'b1) begin fails++; $display("FAIL mid_rmw_busy: got %b want 1", rmw_busy); end
    rst = 1'b1;
    #1;
    checks++; if ({resp.gnt, resp.rvalid, mem_req, mem_we, rmw_busy} !== 5'b0) begin fails++; $display("FAIL mid_rmw_outs: got %b want 00000", {resp.gnt, resp.rvalid, mem_req, mem_we, rmw_busy}); end
    checks++; if (resp.rdata !== 32'h0) begin fails++; $display("FAIL mid_rmw_rdata: got %h want 0", resp.rdata); end
    step();
    checks++; if (resp.rvalid !== 1'b0) begin fails++; $display("FAIL mid_rmw_no_rvalid: got %b want 0", resp.rvalid); end
    drive_idle();
    rst = 1'b0;
    step();
    checks++; if (resp.rvalid !== 1'b0) begin fails++; $display("FAIL post_rmw_rvalid: got %b want 0", resp.rvalid); end
    checks++; if (we_count !== w0) begin fails++; $display("FAIL mid_rmw_we: got %0d want %0d", we_count, w0); end
    drive_req(1'b0, 4'hF, BASE + 32'h1C, 32'h0);
    step();
    checks++; if ({resp.rvalid, resp.rdata} !== {1'b1, 32'hC0DE_0007}) begin fails++; $display("FAIL mid_rmw_readback: got %b/%h want 1/c0de0007", resp.rvalid, resp.rdata); end
    drive_idle();
    step();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_back_to_back();
    test_full_write_read();
    test_partial_rmw();
    test_out_of_range();
    test_be_zero();
    test_reset_mid_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obi_rmw_sram_responder.md
Name: obi_rmw_sram_responder

Overview:
- OBI responder (target end of the obi_req_t/obi_resp_t bus) that fronts a single-port SRAM macro with word-only writes, i.e. no byte enables.
- Serves reads and full-word writes at one request per cycle.
- Converts partial-byte writes into a read-modify-write (RMW) sequence.
- Flags out-of-range accesses with a fixed error pattern.
- Sits between the bus crossbar slave port and a memory bank, serving the core data/instruction initiators.

Parameters:
- NUM_WORDS, 8192, SRAM depth in 32-bit words; power of two, >=2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to NUM_WORDS*4.
- ERR_RDATA, 32'hBADC_AB1E, rdata returned for out-of-range reads.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset.
- req_i, in, obi_req_t: OBI request (req, we, be, addr, wdata).
- resp_o, out, obi_resp_t: OBI response (gnt, rvalid, rdata).
- mem_req_o, out, 1: SRAM chip enable.
- mem_we_o, out, 1: SRAM write enable (full word).
- mem_addr_o, out, $clog2(NUM_WORDS): SRAM word index.
- mem_wdata_o, out, 32: SRAM write data.
- mem_rdata_i, in, 32: SRAM read data, valid the cycle after a read enable.
- rmw_busy_o, out, 1: high while in RMW_WAIT (for perf counters).

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Index and range:
  - idx = addr[2+:$clog2(NUM_WORDS)].
  - in_range = (addr - BASE_ADDR) < NUM_WORDS*4, computed in 32-bit unsigned arithmetic.
  - addr[1:0] is ignored.
- OBI rules:
  - Initiator holds addr/we/be/wdata stable while req && !gnt. The block relies on this and does not latch request fields.
  - Exactly one rvalid pulse per granted transaction, in the cycle after gnt. No backpressure. At most one outstanding transaction.
- States: IDLE, RMW_WAIT. Reset state IDLE.
- While rst_i is high:
  - gnt=0, rvalid=0, rdata=0, mem_req=0, mem_we=0, rmw_busy=0.
- IDLE with req && !in_range:
  - gnt=1, no memory access.
  - Next cycle: rvalid=1; rdata=ERR_RDATA for reads, 0 for writes.
- IDLE with req && in_range && !we:
  - gnt=1; mem_req=1, mem_we=0, mem_addr=idx.
  - Next cycle: rvalid=1, rdata=mem_rdata_i.
- IDLE with req && in_range && we && be==4'hF:
  - gnt=1; mem_req=1, mem_we=1, mem_wdata=wdata.
  - Next cycle: rvalid=1, rdata=0.
- IDLE with req && in_range && we && be==4'h0:
  - gnt=1, no memory access.
  - Next cycle: rvalid=1, rdata=0.
- IDLE with req && in_range && we && be partial:
  - gnt=0; mem_req=1, mem_we=0, mem_addr=idx; go to RMW_WAIT.
- RMW_WAIT:
  - Compute merged[8k+:8] = be[k] ? wdata[8k+:8] : mem_rdata_i[8k+:8].
  - Drive mem_req=1, mem_we=1, mem_addr=idx, mem_wdata=merged; gnt=1; rmw_busy=1.
  - Return to IDLE. Next cycle: rvalid=1, rdata=0.
  - Partial write latency: gnt in the 2nd cycle, rvalid in the 3rd.
- RMW_WAIT is only entered with req high; req dropping there is a protocol violation (assertion). The block still completes the write.
- Back-to-back: a new request may be granted in the same cycle rvalid is returned for the previous one. Throughput is 1 per cycle for reads and full writes, 1 per 2 cycles for partial writes.
- A read after a write to the same word, in consecutive cycles, returns the new data (the SRAM is sequentially consistent).
- rvalid and rdata are registered. The rdata mux select is a registered flag (read / error / write).
- Async reset mid-RMW: the SRAM write is abandoned, the state returns to IDLE, and no rvalid is produced for the abandoned transaction.

Decomposition:
- obi_req_t and obi_resp_t come from obi_pkg.
- Add to core_v_mini_mcu_pkg: a rsp_sel_e enum {RSP_READ, RSP_ZERO, RSP_ERR} and the default error-pattern constant.
- The state enum stays local.
- One combinational sub-module, obi_byte_merge (be, wdata, rdata -> merged), reused by later bus-width adapters.

Test Plan:
- Read after full-word write: write addr BASE+0x10, be=F, wdata=0x11223344; then read the same address → gnt same cycle each; rvalid 1 cycle later; read rdata=0x11223344; mem_we pulses exactly once.
- Partial-write RMW: word holds 0xAABBCCDD; write be=4'b0101, wdata=0x11223344 → gnt in cycle 2, rvalid in cycle 3, rmw_busy high 1 cycle; subsequent read=0xAA22CC44.
- Out-of-range access: read addr=BASE+NUM_WORDS*4 → rvalid with rdata=0xBADCAB1E; write to the same address → rdata=0, mem_req never asserted.
- Back-to-back reads: 8 consecutive reads to words 0..7 → 8 gnts in 8 cycles, rvalid stream delayed by one cycle, data matching preload.
- be=0 write: write with be=0 → granted, rvalid next cycle, mem_req=0, memory unchanged.
- Reset mid-RMW: assert rst_i in the RMW_WAIT cycle → no SRAM write, no rvalid, all outputs 0; after release, a read returns the original word.
